// File: rtl/mac_timestep_scheduler.sv
// Purpose: buffers spike addresses and sequences set/clear/dispatch/capture for the shared MAC bus.
// Latency: a pushed spike reaches source_address_o two cycles after acceptance; every output is registered.
// Backpressure: spike_ready_o drops when the FIFO is full or the state is IDLE/INIT. Optional SPIKE_COUNT_EN adds a per-timestep dispatch counter.
module mac_timestep_scheduler #(
   parameter int                ADDR_W       = 12,
   parameter int                FIFO_DEPTH   = 8,
   parameter int                INIT_CYCLES  = 2,
   parameter int                CLEAR_CYCLES = 2,
   parameter logic [ADDR_W-1:0] IDLE_ADDR    = {ADDR_W{1'b1}}
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              init_req_i,
   input  logic              spike_valid_i,
   input  logic [ADDR_W-1:0] spike_addr_i,
   output logic              spike_ready_o,
   input  logic              timestep_end_i,
   output logic              set_mac_o,
   output logic              clear_mac_o,
   output logic [ADDR_W-1:0] source_address_o,
   input  logic [31:0]       mac_result_i,
   output logic              result_valid_o,
   output logic [31:0]       result_data_o,
   output logic              busy_o,
   output logic              ts_overrun_o,
   output logic [15:0]       spike_count_o
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int TMR_MAX = (INIT_CYCLES > CLEAR_CYCLES) ? INIT_CYCLES : CLEAR_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

   localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_CYCLES - 1);
   localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CLEAR   = 3'd4,
      ST_CAPTURE = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   drain_q, drain_d;
   logic               pend_q, pend_d;
   logic               ovr_q, ovr_d;

   logic [ADDR_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   occ;

   logic               push, pop, flush;

   logic               spike_ready_q;
   logic               set_mac_q;
   logic               clear_mac_q;
   logic [ADDR_W-1:0]  src_addr_q;
   logic               result_valid_q;
   logic [31:0]        result_data_q;
   logic               busy_q;

   // A transfer happens only against the registered ready, so it never lands on a full FIFO.
   assign push = spike_valid_i && spike_ready_q;

   // Next-state logic. A pop is only issued when the next state dispatches, so the address
   // register never shows a spike while set_mac or clear_mac is high.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      drain_d = drain_q;
      pend_d  = pend_q;
      ovr_d   = ovr_q;
      pop     = 1'b0;
      flush   = 1'b0;
      occ     = count_q + CNT_W'(push);
      case (state_q)
         ST_IDLE: begin
            if (init_req_i) begin
               state_d = ST_INIT;
               tmr_d   = INIT_LAST;
               flush   = 1'b1;
            end
         end
         ST_INIT: begin
            pend_d = 1'b0;
            if (tmr_q == '0) state_d = ST_RUN;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         ST_RUN: begin
            if (init_req_i) begin
               // Restart discards the open timestep and everything still queued.
               state_d = ST_INIT;
               tmr_d   = INIT_LAST;
               flush   = 1'b1;
               pend_d  = 1'b0;
               drain_d = '0;
            end else if (timestep_end_i || pend_q) begin
               pend_d = 1'b0;
               if (timestep_end_i && pend_q) ovr_d = 1'b1;
               // Everything queued up to and including this cycle's push closes with this timestep.
               if (occ == '0) begin
                  state_d = ST_CLEAR;
                  tmr_d   = CLEAR_LAST;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = occ;
               end
            end else if (count_q != '0) begin
               pop = 1'b1;
            end
         end
         ST_DRAIN: begin
            // One trailing cycle after the last pop lets that address show while still in DRAIN.
            if (drain_q == '0) begin
               state_d = ST_CLEAR;
               tmr_d   = CLEAR_LAST;
            end else begin
               pop     = 1'b1;
               drain_d = drain_q - CNT_W'(1);
            end
         end
         ST_CLEAR: begin
            if (tmr_q == '0) state_d = ST_CAPTURE;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         ST_CAPTURE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A timestep end arriving while busy is remembered once; a second one is flagged.
      if (timestep_end_i && (state_q inside {ST_DRAIN, ST_CLEAR, ST_CAPTURE})) begin
         if (pend_q) ovr_d  = 1'b1;
         else        pend_d = 1'b1;
      end
   end

   // FIFO pointer and occupancy update; pop is taken before push so full+pop+push is consistent.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         drain_q <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         drain_q <= drain_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= spike_addr_i;
   end

   // Registered outputs, derived from the next state so they line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spike_ready_q  <= 1'b0;
         set_mac_q      <= 1'b0;
         clear_mac_q    <= 1'b0;
         src_addr_q     <= IDLE_ADDR;
         result_valid_q <= 1'b0;
         result_data_q  <= '0;
         busy_q         <= 1'b0;
      end else begin
         spike_ready_q  <= (count_d != FULL_CNT) &&
                           (state_d inside {ST_RUN, ST_DRAIN, ST_CLEAR, ST_CAPTURE});
         set_mac_q      <= (state_d == ST_INIT);
         clear_mac_q    <= (state_d == ST_CLEAR);
         src_addr_q     <= pop ? mem_q[rd_ptr_q] : IDLE_ADDR;
         result_valid_q <= (state_q == ST_CAPTURE);
         if (state_q == ST_CAPTURE) result_data_q <= mac_result_i;
         busy_q         <= !(state_d inside {ST_IDLE, ST_RUN});
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [15:0] disp_cnt_q;
   logic [15:0] spike_count_q;

   // Per-timestep dispatch counter, saturating, published at capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         disp_cnt_q    <= '0;
         spike_count_q <= '0;
      end else if (state_q == ST_INIT) begin
         disp_cnt_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
         spike_count_q <= disp_cnt_q;
         disp_cnt_q    <= '0;
      end else if (pop && (disp_cnt_q != 16'hFFFF)) begin
         disp_cnt_q <= disp_cnt_q + 16'd1;
      end
   end

   assign spike_count_o = spike_count_q;
`else
   assign spike_count_o = 16'd0;
`endif

   assign spike_ready_o    = spike_ready_q;
   assign set_mac_o        = set_mac_q;
   assign clear_mac_o      = clear_mac_q;
   assign source_address_o = src_addr_q;
   assign result_valid_o   = result_valid_q;
   assign result_data_o    = result_data_q;
   assign busy_o           = busy_q;
   assign ts_overrun_o     = ovr_q;

endmodule

// File: tb/tb_mac_timestep_scheduler.sv
// Directed bench for mac_timestep_scheduler: default instance A, small-FIFO/long-clear instance B.
// Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
// Expected values are hand-derived from the block behaviour.
module tb_mac_timestep_scheduler;

`ifdef SPIKE_COUNT_EN
   localparam int SC_EN = 1;
`else
   localparam int SC_EN = 0;
`endif

   logic clk, rst_n;

   logic        init_a, valid_a, ready_a, ts_a, set_a, clr_a, rv_a, busy_a, ovr_a;
   logic [11:0] addr_a, src_a;
   logic [31:0] mac_a, rd_a;
   logic [15:0] sc_a;

   logic        init_b, valid_b, ready_b, ts_b, set_b, clr_b, rv_b, busy_b, ovr_b;
   logic [11:0] addr_b, src_b;
   logic [31:0] mac_b, rd_b;
   logic [15:0] sc_b;

   int vectors = 0;
   int errors  = 0;

   logic [11:0] disp_a[$], disp_b[$];
   int          setn_a, clrn_a, rvn_a, bad_a;
   int          setn_b, clrn_b, rvn_b, bad_b;
   logic [31:0] rdl_a, rdl_b;
   logic [15:0] scl_a, scl_b;

   mac_timestep_scheduler dut_a (
      .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_a), .spike_valid_i(valid_a),
      .spike_addr_i(addr_a), .spike_ready_o(ready_a), .timestep_end_i(ts_a),
      .set_mac_o(set_a), .clear_mac_o(clr_a), .source_address_o(src_a),
      .mac_result_i(mac_a), .result_valid_o(rv_a), .result_data_o(rd_a),
      .busy_o(busy_a), .ts_overrun_o(ovr_a), .spike_count_o(sc_a)
   );

   mac_timestep_scheduler #(.FIFO_DEPTH(4), .CLEAR_CYCLES(8)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_b), .spike_valid_i(valid_b),
      .spike_addr_i(addr_b), .spike_ready_o(ready_b), .timestep_end_i(ts_b),
      .set_mac_o(set_b), .clear_mac_o(clr_b), .source_address_o(src_b),
      .mac_result_i(mac_b), .result_valid_o(rv_b), .result_data_o(rd_b),
      .busy_o(busy_b), .ts_overrun_o(ovr_b), .spike_count_o(sc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic clr_obs();
      disp_a.delete(); disp_b.delete();
      setn_a = 0; clrn_a = 0; rvn_a = 0; bad_a = 0; rdl_a = '0; scl_a = '0;
      setn_b = 0; clrn_b = 0; rvn_b = 0; bad_b = 0; rdl_b = '0; scl_b = '0;
   endtask

   task automatic obs();
      if (src_a !== 12'hFFF) disp_a.push_back(src_a);
      if (set_a) setn_a++;
      if (clr_a) clrn_a++;
      if (rv_a) begin rvn_a++; rdl_a = rd_a; scl_a = sc_a; end
      if ((set_a || clr_a) && src_a !== 12'hFFF) bad_a++;
      if (set_a && clr_a) bad_a++;
      if (src_b !== 12'hFFF) disp_b.push_back(src_b);
      if (set_b) setn_b++;
      if (clr_b) clrn_b++;
      if (rv_b) begin rvn_b++; rdl_b = rd_b; scl_b = sc_b; end
      if ((set_b || clr_b) && src_b !== 12'hFFF) bad_b++;
      if (set_b && clr_b) bad_b++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      obs();
   endtask

   task automatic test_reset();
      logic [67:0] got;
      rst_n = 1'b0;
      init_a = 0; valid_a = 0; addr_a = '0; ts_a = 0; mac_a = '0;
      init_b = 0; valid_b = 0; addr_b = '0; ts_b = 0; mac_b = '0;
      repeat (3) tick();
      got = {set_a, clr_a, src_a, ready_a, rv_a, rd_a, busy_a, ovr_a, sc_a};
      vectors++;
      if (got !== {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0}) begin
         errors++; $display("FAIL reset_a: got %h want %h", got, {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0});
      end
      got = {set_b, clr_b, src_b, ready_b, rv_b, rd_b, busy_b, ovr_b, sc_b};
      vectors++;
      if (got !== {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0}) begin
         errors++; $display("FAIL reset_b: got %h want %h", got, {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0});
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if (ready_a !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", ready_a); end
   endtask

   task automatic test_init();
      clr_obs();
      init_a = 1; init_b = 1;
      tick();
      init_a = 0; init_b = 0;
      repeat (5) tick();
      vectors++;
      if (setn_a !== 2) begin errors++; $display("FAIL init_set_cycles_a: got %0d want 2", setn_a); end
      vectors++;
      if (setn_b !== 2) begin errors++; $display("FAIL init_set_cycles_b: got %0d want 2", setn_b); end
      vectors++;
      if ({ready_a, busy_a, set_a} !== 3'b100) begin
         errors++; $display("FAIL init_run_a: got ready/busy/set %b want 100", {ready_a, busy_a, set_a});
      end
      vectors++;
      if ({ready_b, busy_b} !== 2'b10) begin
         errors++; $display("FAIL init_run_b: got ready/busy %b want 10", {ready_b, busy_b});
      end
   endtask

   task automatic test_timestep();
      mac_a = 32'h42F43851;
      clr_obs();
      valid_a = 1; addr_a = 12'd8;
      tick();
      addr_a = 12'd10;
      tick();
      valid_a = 0; ts_a = 1;
      tick();
      ts_a = 0;
      repeat (10) tick();
      vectors++;
      if (disp_a.size() !== 2) begin errors++; $display("FAIL ts_disp_count: got %0d want 2", disp_a.size()); end
      vectors++;
      if ({disp_a[0], disp_a[1]} !== {12'd8, 12'd10}) begin
         errors++; $display("FAIL ts_disp_order: got %h %h want 008 00a", disp_a[0], disp_a[1]);
      end
      vectors++;
      if (clrn_a !== 2) begin errors++; $display("FAIL ts_clear_cycles: got %0d want 2", clrn_a); end
      vectors++;
      if (rvn_a !== 1) begin errors++; $display("FAIL ts_result_pulses: got %0d want 1", rvn_a); end
      vectors++;
      if (rdl_a !== 32'h42F43851) begin errors++; $display("FAIL ts_result_data: got %h want 42f43851", rdl_a); end
      vectors++;
      if (scl_a !== 16'(SC_EN * 2)) begin errors++; $display("FAIL ts_spike_count: got %0d want %0d", scl_a, SC_EN * 2); end
      vectors++;
      if (bad_a !== 0) begin errors++; $display("FAIL ts_bus_overlap: got %0d want 0", bad_a); end
   endtask

   task automatic test_same_cycle_push();
      mac_a = 32'h3F800000;
      clr_obs();
      valid_a = 1; addr_a = 12'd9; ts_a = 1;
      tick();
      valid_a = 0; ts_a = 0;
      repeat (10) tick();
      vectors++;
      if (disp_a.size() !== 1 || disp_a[0] !== 12'd9) begin
         errors++; $display("FAIL same_cycle_disp: got n=%0d first=%h want n=1 first=009", disp_a.size(), disp_a[0]);
      end
      vectors++;
      if ({rvn_a, rdl_a} !== {32'd1, 32'h3F800000}) begin
         errors++; $display("FAIL same_cycle_result: got n=%0d data=%h want n=1 data=3f800000", rvn_a, rdl_a);
      end
      vectors++;
      if (scl_a !== 16'(SC_EN)) begin errors++; $display("FAIL same_cycle_count: got %0d want %0d", scl_a, SC_EN); end
      vectors++;
      if ({clrn_a, bad_a} !== {32'd2, 32'd0}) begin
         errors++; $display("FAIL same_cycle_clear: got clr=%0d bad=%0d want clr=2 bad=0", clrn_a, bad_a);
      end
   endtask

   task automatic test_fifo_full_during_clear();
      int   idx;
      logic acc, r4, c4, a5_clr;
      int   a5_disp;
      logic [59:0] got5;
      idx = 0; r4 = 1'bx; c4 = 1'bx; a5_clr = 1'bx; a5_disp = -1;
      mac_b = 32'h11111111;
      clr_obs();
      ts_b = 1;
      tick();
      ts_b = 0;
      for (int c = 0; c < 30; c++) begin
         valid_b = (idx < 5);
         addr_b  = 12'(idx + 1);
         acc     = valid_b && ready_b;
         if (acc && idx == 4) begin a5_disp = disp_b.size(); a5_clr = clr_b; end
         tick();
         if (acc) begin
            idx++;
            if (idx == 4) begin r4 = ready_b; c4 = clr_b; end
         end
      end
      valid_b = 0;
      vectors++;
      if (idx !== 5) begin errors++; $display("FAIL full_accepted: got %0d want 5 within budget", idx); end
      vectors++;
      if ({r4, c4} !== 2'b01) begin errors++; $display("FAIL full_ready_low: got ready/clear %b want 01", {r4, c4}); end
      vectors++;
      if ({a5_disp, a5_clr} !== {32'd1, 1'b0}) begin
         errors++; $display("FAIL full_fifth_after_pop: got popped=%0d clear=%b want popped=1 clear=0", a5_disp, a5_clr);
      end
      got5 = {disp_b[0], disp_b[1], disp_b[2], disp_b[3], disp_b[4]};
      vectors++;
      if (disp_b.size() !== 5 || got5 !== {12'd1, 12'd2, 12'd3, 12'd4, 12'd5}) begin
         errors++; $display("FAIL full_disp_order: got n=%0d %h want n=5 001002003004005", disp_b.size(), got5);
      end
      vectors++;
      if ({clrn_b, bad_b, rvn_b} !== {32'd8, 32'd0, 32'd1}) begin
         errors++; $display("FAIL full_clear_window: got clr=%0d bad=%0d rv=%0d want 8 0 1", clrn_b, bad_b, rvn_b);
      end
   endtask

   task automatic test_overrun();
      clr_obs();
      ts_b = 1; tick();
      ts_b = 0; tick();
      ts_b = 1; tick();
      ts_b = 0; tick();
      ts_b = 1; tick();
      ts_b = 0;
      vectors++;
      if ({clr_b, ovr_b} !== 2'b11) begin errors++; $display("FAIL overrun_flag: got clear/ovr %b want 11", {clr_b, ovr_b}); end
      repeat (40) tick();
      vectors++;
      if ({rvn_b, clrn_b} !== {32'd2, 32'd16}) begin
         errors++; $display("FAIL overrun_extra_ts: got rv=%0d clr=%0d want rv=2 clr=16", rvn_b, clrn_b);
      end
      vectors++;
      if ({ovr_b, ovr_a} !== 2'b10) begin errors++; $display("FAIL overrun_sticky: got b/a %b want 10", {ovr_b, ovr_a}); end
   endtask

   task automatic test_reset_mid_drain();
      logic [67:0] got;
      clr_obs();
      valid_a = 1; addr_a = 12'd1; tick();
      addr_a = 12'd2; tick();
      addr_a = 12'd3; ts_a = 1; tick();
      valid_a = 0; ts_a = 0;
      vectors++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b want 1", busy_a); end
      rst_n = 1'b0;
      tick();
      got = {set_a, clr_a, src_a, ready_a, rv_a, rd_a, busy_a, ovr_a, sc_a};
      vectors++;
      if (got !== {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0}) begin
         errors++; $display("FAIL drain_reset: got %h want %h", got, {2'b00, 12'hFFF, 2'b00, 32'h0, 2'b00, 16'h0});
      end
      rst_n = 1'b1;
      clr_obs();
      ts_a = 1; tick();
      ts_a = 0; repeat (4) tick();
      vectors++;
      if ({ready_a, busy_a, clrn_a} !== {1'b0, 1'b0, 32'd0}) begin
         errors++; $display("FAIL drain_stays_idle: got ready=%b busy=%b clr=%0d want 0 0 0", ready_a, busy_a, clrn_a);
      end
   endtask

   task automatic test_back_to_back();
      init_a = 1; tick();
      init_a = 0; repeat (4) tick();
      mac_a = 32'hC0490FDB;
      clr_obs();
      valid_a = 1; addr_a = 12'h7; ts_a = 1; tick();
      valid_a = 0; ts_a = 0;
      repeat (10) tick();
      vectors++;
      if (disp_a.size() !== 1 || disp_a[0] !== 12'h7) begin
         errors++; $display("FAIL resume_disp: got n=%0d first=%h want n=1 first=007", disp_a.size(), disp_a[0]);
      end
      vectors++;
      if ({rvn_a, rdl_a} !== {32'd1, 32'hC0490FDB}) begin
         errors++; $display("FAIL resume_result: got n=%0d data=%h want n=1 data=c0490fdb", rvn_a, rdl_a);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_timestep();
      test_same_cycle_push();
      test_fifo_full_during_clear();
      test_overrun();
      test_reset_mid_drain();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
